// File: rtl/pkt_pkg.sv
// ============================================================
// pkt_pkg : shared constants and types for packet_length_counter
// Rev 1.0
// ============================================================
`default_nettype none

package pkt_pkg;

  localparam int DW_DEF    = 128;
  localparam int LEN_W_DEF = 16;

  // Width needed to hold the number of set bits in a DW/8-bit keep vector.
  function automatic int pcnt_w(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  localparam int PCNT_W_DEF = pcnt_w(DW_DEF);

  typedef logic [LEN_W_DEF-1:0] len_word_t;

endpackage

`default_nettype wire

// File: rtl/keep_popcount.sv
// ============================================================
// keep_popcount : combinational count of set tkeep bits (bytes in a beat)
// Rev 1.0
// ============================================================
`default_nettype none

module keep_popcount
  import pkt_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW/8-1:0]       keep,
  output logic [pcnt_w(DW)-1:0] count
);

  localparam int PW = pcnt_w(DW);

  always_comb begin
    count = '0;
    for (int i = 0; i < DW / 8; i++) begin
      count = count + PW'(keep[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_length_counter.sv
// ============================================================
// packet_length_counter : AXIS register slice + per-packet byte length
// Option macro PKT_LEN_SATURATE_EN (saturating length + len_tuser). Rev 1.0
// ============================================================
`default_nettype none

module packet_length_counter
  import pkt_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DW-1:0]     axis_in_tdata,
  input  logic [DW/8-1:0]   axis_in_tkeep,
  input  logic              axis_in_tlast,
  input  logic              axis_in_tvalid,
  output logic              axis_in_tready,
  output logic [DW-1:0]     axis_out_tdata,
  output logic [DW/8-1:0]   axis_out_tkeep,
  output logic              axis_out_tlast,
  output logic              axis_out_tvalid,
  input  logic              axis_out_tready,
  output logic [LEN_W-1:0]  len_tdata,
  output logic              len_tvalid,
  input  logic              len_tready
`ifdef PKT_LEN_SATURATE_EN
  ,
  output logic              len_tuser
`endif
);

  localparam int PW = pcnt_w(DW);

  logic [PW-1:0]    beat_bytes;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_next;
  logic             accept;

  keep_popcount #(
    .DW (DW)
  ) u_keep_popcount (
    .keep  (axis_in_tkeep),
    .count (beat_bytes)
  );

  // Accept only when both downstream slots are free or draining this cycle.
  assign axis_in_tready = resetn
                        && (!axis_out_tvalid || axis_out_tready)
                        && (!len_tvalid || len_tready);
  assign accept = axis_in_tvalid && axis_in_tready;

`ifdef PKT_LEN_SATURATE_EN
  logic [LEN_W:0] sum_full;
  logic           ovf_now;
  logic           ovf_seen;

  assign sum_full = {1'b0, byte_cnt} + (LEN_W+1)'(beat_bytes);
  assign ovf_now  = sum_full[LEN_W];
  assign cnt_next = ovf_now ? '1 : sum_full[LEN_W-1:0];
`else
  assign cnt_next = byte_cnt + LEN_W'(beat_bytes);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      len_tdata       <= '0;
      len_tvalid      <= 1'b0;
      byte_cnt        <= '0;
`ifdef PKT_LEN_SATURATE_EN
      len_tuser       <= 1'b0;
      ovf_seen        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        axis_out_tdata  <= axis_in_tdata;
        axis_out_tkeep  <= axis_in_tkeep;
        axis_out_tlast  <= axis_in_tlast;
        axis_out_tvalid <= 1'b1;
      end else if (axis_out_tready) begin
        axis_out_tvalid <= 1'b0;
      end

      if (accept && axis_in_tlast) begin
        len_tdata  <= cnt_next;
        len_tvalid <= 1'b1;
        byte_cnt   <= '0;
`ifdef PKT_LEN_SATURATE_EN
        len_tuser  <= ovf_seen | ovf_now;
        ovf_seen   <= 1'b0;
`endif
      end else begin
        if (len_tready) begin
          len_tvalid <= 1'b0;
        end
        if (accept) begin
          byte_cnt <= cnt_next;
`ifdef PKT_LEN_SATURATE_EN
          ovf_seen <= ovf_seen | ovf_now;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_length_counter.sv
// ============================================================
// tb_packet_length_counter : directed + random bench with queue-based model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_packet_length_counter;

  localparam int DW     = 128;
  localparam int KW     = DW / 8;
  localparam int LW     = 8;
  localparam int MAXLEN = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] axis_in_tdata;
  logic [KW-1:0] axis_in_tkeep;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [DW-1:0] axis_out_tdata;
  logic [KW-1:0] axis_out_tkeep;
  logic          axis_out_tlast;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic [LW-1:0] len_tdata;
  logic          len_tvalid;
  logic          len_tready;
`ifdef PKT_LEN_SATURATE_EN
  logic          len_tuser;
`endif

  packet_length_counter #(
    .DW    (DW),
    .LEN_W (LW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tkeep   (axis_in_tkeep),
    .axis_in_tlast   (axis_in_tlast),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .len_tdata       (len_tdata),
    .len_tvalid      (len_tvalid),
    .len_tready      (len_tready)
`ifdef PKT_LEN_SATURATE_EN
    ,
    .len_tuser       (len_tuser)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_len[$];
  bit    exp_usr[$];
  int    got_len[$];
  int    errors = 0;
  int    checks = 0;
  int    pkt_bytes = 0;
  int    out_mode = 0;
  int    len_mode = 0;
  bit    prev_acc = 1'b0;
  bit    prev_last = 1'b0;
  beat_t prev_beat;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check/score at negedge, then advance to just after posedge.
  task automatic cycle(output bit acc);
    beat_t b;
    beat_t nb;
    bit    exp_rdy;
    @(negedge clk);
    acc = 1'b0;
    if (!resetn) begin
      exp_beats.delete();
      exp_len.delete();
      exp_usr.delete();
      pkt_bytes = 0;
      prev_acc  = 1'b0;
      prev_last = 1'b0;
      chk("tready_in_reset", axis_in_tready, 0);
    end else begin
      exp_rdy = (!axis_out_tvalid || axis_out_tready) && (!len_tvalid || len_tready);
      chk("tready", axis_in_tready, exp_rdy);
      if (prev_acc) begin
        chk("out_latency_valid", axis_out_tvalid, 1);
        chk("out_latency_data", axis_out_tdata, prev_beat.d);
        chk("out_latency_keep", axis_out_tkeep, prev_beat.k);
        chk("out_latency_last", axis_out_tlast, prev_beat.l);
      end
      if (prev_last) begin
        chk("len_latency_valid", len_tvalid, 1);
        chk("len_latency_data", len_tdata, exp_len[$]);
      end
      if (axis_out_tvalid && axis_out_tready) begin
        chk("beat_expected", exp_beats.size() > 0, 1);
        if (exp_beats.size() > 0) begin
          b = exp_beats.pop_front();
          chk("out_tdata", axis_out_tdata, b.d);
          chk("out_tkeep", axis_out_tkeep, b.k);
          chk("out_tlast", axis_out_tlast, b.l);
        end
      end
      if (len_tvalid && len_tready) begin
        got_len.push_back(int'(len_tdata));
        chk("len_expected", exp_len.size() > 0, 1);
        if (exp_len.size() > 0) begin
          chk("len_tdata", len_tdata, exp_len.pop_front());
`ifdef PKT_LEN_SATURATE_EN
          chk("len_tuser", len_tuser, exp_usr.pop_front());
`else
          void'(exp_usr.pop_front());
`endif
        end
      end
      acc = axis_in_tvalid && axis_in_tready;
      prev_acc  = acc;
      prev_last = acc && axis_in_tlast;
      if (acc) begin
        nb.d = axis_in_tdata;
        nb.k = axis_in_tkeep;
        nb.l = axis_in_tlast;
        exp_beats.push_back(nb);
        prev_beat = nb;
        pkt_bytes += $countones(axis_in_tkeep);
        if (axis_in_tlast) begin
`ifdef PKT_LEN_SATURATE_EN
          exp_len.push_back(pkt_bytes > MAXLEN ? MAXLEN : pkt_bytes);
`else
          exp_len.push_back(pkt_bytes % (MAXLEN + 1));
`endif
          exp_usr.push_back(pkt_bytes > MAXLEN);
          pkt_bytes = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    case (out_mode)
      0:       axis_out_tready = 1'b1;
      1:       axis_out_tready = ~axis_out_tready;
      default: axis_out_tready = 1'($urandom_range(0, 1));
    endcase
    if (len_mode == 2) len_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [KW-1:0] keep, input bit last);
    bit acc;
    int n;
    n = 0;
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
    axis_in_tkeep  = keep;
    axis_in_tlast  = last;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 300);
    chk("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    axis_in_tvalid  = 1'b0;
    out_mode        = 0;
    len_mode        = 0;
    axis_out_tready = 1'b1;
    len_tready      = 1'b1;
    while ((exp_beats.size() > 0 || exp_len.size() > 0 || axis_out_tvalid || len_tvalid) && n < 200) begin
      cycle(a);
      n++;
    end
    chk("drain_beats_empty", exp_beats.size(), 0);
    chk("drain_lens_empty", exp_len.size(), 0);
    chk("drain_out_idle", axis_out_tvalid, 0);
    chk("drain_len_idle", len_tvalid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_tvalid"}, axis_out_tvalid, 0);
    chk({tag, "_out_tdata"}, axis_out_tdata, 0);
    chk({tag, "_out_tkeep"}, axis_out_tkeep, 0);
    chk({tag, "_out_tlast"}, axis_out_tlast, 0);
    chk({tag, "_len_tvalid"}, len_tvalid, 0);
    chk({tag, "_len_tdata"}, len_tdata, 0);
    chk({tag, "_in_tready"}, axis_in_tready, 0);
  endtask

  initial begin
    bit a;
    resetn          = 1'b0;
    axis_in_tdata   = '0;
    axis_in_tkeep   = '0;
    axis_in_tlast   = 1'b0;
    axis_in_tvalid  = 1'b0;
    axis_out_tready = 1'b1;
    len_tready      = 1'b1;

    // Power-on reset.
    repeat (3) cycle(a);
    chk_all_zero("por");
    resetn = 1'b1;

    // 3-beat packet 16+16+8 = 40 bytes.
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h00FF, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("p3_len_valid", len_tvalid, 1);
    chk("p3_len", len_tdata, 40);
    drain();

    // Single-byte packet, then a packet whose first beat carries no bytes.
    send_beat(16'h0001, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("single_len", len_tdata, 1);
    send_beat(16'h0000, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("zero_keep_len", len_tdata, 16);
    drain();

    // Length FIFO backpressure stalls the next packet.
    len_tready = 1'b0;
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("a_len", len_tdata, 32);
    axis_in_tvalid = 1'b1;
    axis_in_tkeep  = 16'hFFFF;
    axis_in_tlast  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(a);
      chk("b_stalled_acc", a, 0);
      chk("b_stalled_ready", axis_in_tready, 0);
      chk("a_len_held", len_tdata, 32);
    end
    len_tready = 1'b1;
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h00FF, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("b_len", len_tdata, 24);
    drain();

    // Toggling output ready across 4 back-to-back packets.
    got_len.delete();
    out_mode = 1;
    for (int p = 1; p <= 4; p++) begin
      for (int bt = 1; bt <= p; bt++) send_beat(16'hFFFF, bt == p);
    end
    drain();
    chk("toggle_len_count", got_len.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_len.size()) chk("toggle_len_val", got_len[i], 16 * (i + 1));
    end

    // Reset in mid-packet discards the partial count.
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    resetn = 1'b0;
    axis_in_tvalid = 1'b0;
    cycle(a);
    cycle(a);
    chk_all_zero("midrst");
    resetn = 1'b1;
    send_beat(16'hFFFF, 1'b1);
    axis_in_tvalid = 1'b0;
    chk("post_reset_len", len_tdata, 16);
    drain();

    // 17 x 16 = 272 bytes overflows an 8-bit length.
    for (int bt = 1; bt <= 17; bt++) send_beat(16'hFFFF, bt == 17);
    axis_in_tvalid = 1'b0;
`ifdef PKT_LEN_SATURATE_EN
    chk("ovf_len_sat", len_tdata, 255);
    chk("ovf_tuser", len_tuser, 1);
`else
    chk("ovf_len_wrap", len_tdata, 16);
`endif
    drain();

    // Random packets, keeps, gaps and backpressure.
    out_mode = 2;
    len_mode = 2;
    for (int p = 0; p < 12; p++) begin
      int nb;
      nb = $urandom_range(1, 20);
      for (int bt = 1; bt <= nb; bt++) send_beat(16'($urandom_range(0, 65535)), bt == nb);
      axis_in_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) cycle(a);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
